// File: rtl/cast_pkg.sv
// Shared flit-type encodings and framing state for the cast router eject path.
// The flit width and stream-id field macros default here when no project header has set them.
`ifndef DW
`define DW 32
`endif
`ifndef STREAM_ID_H
`define STREAM_ID_H 29
`endif
`ifndef STREAM_ID_L
`define STREAM_ID_L 26
`endif

package cast_pkg;

  typedef logic [1:0] flit_type_t;

  localparam flit_type_t FT_BODY   = 2'b00;
  localparam flit_type_t FT_HEAD   = 2'b01;
  localparam flit_type_t FT_TAIL   = 2'b10;
  localparam flit_type_t FT_SINGLE = 2'b11;

  localparam int unsigned FLIT_CNT_W = 16;
  localparam int unsigned PKT_CNT_W  = 16;

  typedef enum logic {
    IDLE,
    IN_PKT
  } eject_state_t;

endpackage

// File: rtl/cast_eject_fifo.sv
// First-word-fall-through flit buffer for the eject stage.
// full/empty are registered from the next occupancy; full is held high in reset so nothing is written.
module cast_eject_fifo #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH_LOG = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG;
  localparam int unsigned CNT_W = DEPTH_LOG + 1;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr;
  logic [DEPTH_LOG-1:0] rd_ptr;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_nxt;
  logic                 wr_fire;
  logic                 rd_fire;

  assign wr_fire = wr_en & ~full;
  assign rd_fire = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    cnt_nxt = cnt;
    if (wr_fire && !rd_fire) begin
      cnt_nxt = cnt + CNT_W'(1);
    end else if (rd_fire && !wr_fire) begin
      cnt_nxt = cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full   <= 1'b1;
      empty  <= 1'b1;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + DEPTH_LOG'(1);
      if (rd_fire) rd_ptr <= rd_ptr + DEPTH_LOG'(1);
      cnt   <= cnt_nxt;
      full  <= (cnt_nxt == CNT_W'(DEPTH));
      empty <= (cnt_nxt == CNT_W'(0));
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (wr_fire) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/cast_eject_stage.sv
// Destination-side eject stage: buffers flits from the router local port, tracks packet
// framing on the consumer side and returns one credit pulse per packet consumed.
import cast_pkg::*;

module cast_eject_stage #(
  parameter int unsigned DEPTH_LOG = 4,
  parameter int unsigned FCpl      = 16,
  parameter int unsigned CHECK_LEN = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           valid_i,
  input  logic [`DW-1:0] data_i,
  output logic           ready_o,
  output logic           valid_o,
  output logic [`DW-1:0] data_o,
  input  logic           ready_i,
  output logic           credit_upd_o,
  output logic [15:0]    pkt_cnt_o,
  output logic           err_seq_o,
  output logic           err_len_o
);

  localparam int unsigned LEN_W = FLIT_CNT_W + 1;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fire;
  flit_type_t            ftype;

  eject_state_t          state_q, state_d;
  logic [FLIT_CNT_W-1:0] flit_cnt_q, flit_cnt_d;
  logic                  pend_q, pend_d;
  logic                  credit_d;
  logic                  seq_set;
  logic                  len_bad;
  logic [1:0]            ends;
  logic [1:0]            owed;

  cast_eject_fifo #(
    .WIDTH     (`DW),
    .DEPTH_LOG (DEPTH_LOG)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_en   (valid_i),
    .wr_data (data_i),
    .rd_en   (ready_i),
    .rd_data (data_o),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign ready_o = ~fifo_full;
  assign valid_o = ~fifo_empty;
  assign fire    = valid_o & ready_i;
  assign ftype   = flit_type_t'(data_o[`DW-1:`DW-2]);

  function automatic logic len_mismatch(input logic [LEN_W-1:0] len);
    return (CHECK_LEN != 0) && (len != LEN_W'(FCpl));
  endfunction

  // Framing FSM plus credit bookkeeping; an aborting SINGLE ends two packets in one fire.
  always_comb begin
    state_d    = state_q;
    flit_cnt_d = flit_cnt_q;
    seq_set    = 1'b0;
    len_bad    = 1'b0;
    ends       = 2'd0;
    if (fire) begin
      unique case (state_q)
        IDLE: begin
          unique case (ftype)
            FT_HEAD: begin
              state_d    = IN_PKT;
              flit_cnt_d = FLIT_CNT_W'(1);
            end
            FT_SINGLE: begin
              ends    = 2'd1;
              len_bad = len_mismatch(LEN_W'(1));
            end
            default: seq_set = 1'b1;
          endcase
        end
        IN_PKT: begin
          unique case (ftype)
            FT_BODY: begin
              if (flit_cnt_q != '1) flit_cnt_d = flit_cnt_q + FLIT_CNT_W'(1);
            end
            FT_TAIL: begin
              ends    = 2'd1;
              len_bad = len_mismatch(LEN_W'(flit_cnt_q) + LEN_W'(1));
              state_d = IDLE;
            end
            FT_HEAD: begin
              seq_set    = 1'b1;
              ends       = 2'd1;
              flit_cnt_d = FLIT_CNT_W'(1);
            end
            default: begin
              seq_set = 1'b1;
              ends    = 2'd2;
              len_bad = len_mismatch(LEN_W'(1));
              state_d = IDLE;
            end
          endcase
        end
        default: state_d = IDLE;
      endcase
    end
    owed     = ends + 2'(pend_q);
    credit_d = (owed != 2'd0);
    pend_d   = (owed > 2'd1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      flit_cnt_q   <= '0;
      pend_q       <= 1'b0;
      credit_upd_o <= 1'b0;
      pkt_cnt_o    <= '0;
      err_seq_o    <= 1'b0;
      err_len_o    <= 1'b0;
    end else begin
      state_q      <= state_d;
      flit_cnt_q   <= flit_cnt_d;
      pend_q       <= pend_d;
      credit_upd_o <= credit_d;
      pkt_cnt_o    <= pkt_cnt_o + PKT_CNT_W'(credit_d);
      err_seq_o    <= err_seq_o | seq_set;
      err_len_o    <= err_len_o | len_bad;
    end
  end

endmodule
